bounce_emulator: RTL and testbench

- Stimulus generator: the transmit-side counterpart of the button debouncer.
- Takes a clean, clock-synchronous press request and drives an active-low pseudo-button pad signal.
- On each request change, the pad signal bounces a fixed number of times with pseudo-random gaps, then settles.
- Loops back on-board to the debouncer input for self-test of the slow-clock counter design.

---
 rtl/bounce_emulator.sv | 137 +++++++++++++
 tb/tb_bounce_emulator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bounce_emulator.sv
// Pseudo-button pad driver: turns a clean press request into an active-low pad
// signal that bounces with LFSR-timed gaps before settling at the requested level.
module bounce_emulator #(
    parameter int          BOUNCE_COUNT  = 6,
    parameter int          GAP_BITS      = 8,
    parameter int          SETTLE_CYCLES = 1024,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic clk,
    input  logic resetn,
    input  logic press,
    output logic buttonOut,
    output logic busy,
    output logic done
);

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int TOG_W = (BOUNCE_COUNT > 0) ? $clog2(BOUNCE_COUNT + 1) : 1;
    localparam int GAP_W = GAP_BITS + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [TOG_W-1:0] TOG_LOAD = TOG_W'(BOUNCE_COUNT);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        SETTLE
    } state_t;

    state_t             state_reg, state_next;
    logic [15:0]        lfsr_reg, lfsr_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic [TOG_W-1:0]   toggles_reg, toggles_next;
    logic [SET_W-1:0]   settle_reg, settle_next;
    logic               target_reg, target_next;
    logic               pad_reg, pad_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic [GAP_W-1:0]   gap_load;

    // Galois right-shift LFSR; the feedback bit is the one shifted out of bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_lfsr
            assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (LFSR_MASK[gi] & lfsr_reg[0]);
        end
    endgenerate
    assign lfsr_next[15] = LFSR_MASK[15] & lfsr_reg[0];

    assign gap_load = GAP_W'(lfsr_reg[GAP_BITS-1:0]) + GAP_W'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            lfsr_reg    <= SEED;
            gap_reg     <= '0;
            toggles_reg <= '0;
            settle_reg  <= '0;
            target_reg  <= 1'b1;
            pad_reg     <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lfsr_reg    <= lfsr_next;
            gap_reg     <= gap_next;
            toggles_reg <= toggles_next;
            settle_reg  <= settle_next;
            target_reg  <= target_next;
            pad_reg     <= pad_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        gap_next     = gap_reg;
        toggles_next = toggles_reg;
        settle_next  = settle_reg;
        target_next  = target_reg;
        pad_next     = pad_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                // Pad is active-low, so press equal to the pad level means they disagree.
                if (press == pad_reg) begin
                    target_next  = ~press;
                    toggles_next = TOG_LOAD;
                    busy_next    = 1'b1;
                    if (BOUNCE_COUNT > 0) begin
                        gap_next   = gap_load;
                        state_next = BOUNCE;
                    end else begin
                        settle_next = '0;
                        pad_next    = ~press;
                        state_next  = SETTLE;
                    end
                end
            end
            BOUNCE: begin
                if (gap_reg == GAP_W'(1)) begin
                    toggles_next = toggles_reg - TOG_W'(1);
                    gap_next     = gap_load;
                    // The last toggle lands on the target level whatever the count parity.
                    if (toggles_reg == TOG_W'(1)) begin
                        pad_next    = target_reg;
                        settle_next = '0;
                        state_next  = SETTLE;
                    end else begin
                        pad_next = ~pad_reg;
                    end
                end else begin
                    gap_next = gap_reg - GAP_W'(1);
                end
            end
            SETTLE: begin
                if (settle_reg == SET_LAST) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    settle_next = settle_reg + SET_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign buttonOut = pad_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_bounce_emulator.sv
// Directed bench for bounce_emulator: bounce timing against an LFSR model,
// settle/done timing, ignored presses while busy, zero-bounce variant and reset abort.
module tb_bounce_emulator;

    localparam int BC = 4;
    localparam int SC = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic press = 1'b0;
    logic pad, busy, done;
    logic press0 = 1'b0;
    logic pad0, busy0, done0;
    logic [15:0] model_lfsr;
    int total = 0;
    int passed = 0;

    bounce_emulator #(.BOUNCE_COUNT(BC), .GAP_BITS(3), .SETTLE_CYCLES(SC), .SEED(16'hACE1)) dut (
        .clk(clk), .resetn(resetn), .press(press), .buttonOut(pad), .busy(busy), .done(done)
    );

    bounce_emulator #(.BOUNCE_COUNT(0), .GAP_BITS(3), .SETTLE_CYCLES(SC), .SEED(16'hACE1)) dut0 (
        .clk(clk), .resetn(resetn), .press(press0), .buttonOut(pad0), .busy(busy0), .done(done0)
    );

    always #5 clk = ~clk;

    // Reference Galois LFSR, mask 0xB400, shifting right.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) model_lfsr <= 16'hACE1;
        else model_lfsr <= (model_lfsr >> 1) ^ (model_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] hand [0:3];
        hand[0] = 16'hACE1; hand[1] = 16'hE270; hand[2] = 16'h7138; hand[3] = 16'h389C;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({pad, busy, done} !== 3'b100) $display("FAIL in_reset got=%b exp=100", {pad, busy, done}); else passed++;
        end
        resetn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            total++; if ({pad, busy, done} !== 3'b100) $display("FAIL idle_outputs cyc=%0d got=%b exp=100", i, {pad, busy, done}); else passed++;
            if (i < 4) begin
                total++; if (dut.lfsr_reg !== hand[i]) $display("FAIL lfsr_hand cyc=%0d got=%h exp=%h", i, dut.lfsr_reg, hand[i]); else passed++;
            end else begin
                total++; if (dut.lfsr_reg !== model_lfsr) $display("FAIL lfsr_model cyc=%0d got=%h exp=%h", i, dut.lfsr_reg, model_lfsr); else passed++;
            end
            step();
        end
        $display("reset: 100 idle cycles checked, lfsr now %h", model_lfsr);
    endtask

    // One full sequence; ends at the negedge where done is visible.
    task automatic run_seq(input logic p, input bit drive, input bit glitch, input bit late_flip);
        logic level, tgt, exp_pad;
        int g, ng, first_gap;
        level = pad;
        tgt = ~p;
        ng = 0;
        if (drive) press = p;
        g = 1 + int'(model_lfsr[2:0]);
        first_gap = g;
        step();
        total++; if (busy !== 1'b1 || pad !== level || done !== 1'b0)
            $display("FAIL seq_start got busy=%b pad=%b done=%b exp busy=1 pad=%b done=0", busy, pad, done, level); else passed++;
        if (glitch) press = ~p;
        for (int t = 1; t <= BC; t++) begin
            for (int c = 1; c <= g; c++) begin
                if (glitch && t == 1 && c == 1) press = p;
                if (c == g) ng = 1 + int'(model_lfsr[2:0]);
                step();
                if (c == g) level = (t == BC) ? tgt : ~level;
                exp_pad = level;
                total++; if (pad !== exp_pad || busy !== 1'b1 || done !== 1'b0)
                    $display("FAIL bounce t=%0d c=%0d got pad=%b busy=%b done=%b exp pad=%b busy=1 done=0", t, c, pad, busy, done, exp_pad); else passed++;
            end
            g = ng;
        end
        for (int s = 1; s <= SC; s++) begin
            if (late_flip && s == 8) press = ~p;
            step();
            total++; if (pad !== tgt || busy !== (s < SC) || done !== (s == SC))
                $display("FAIL settle s=%0d got pad=%b busy=%b done=%b exp pad=%b busy=%b done=%b",
                         s, pad, busy, done, tgt, (s < SC), (s == SC)); else passed++;
        end
        $display("sequence press=%b first_gap=%0d glitch=%0d late_flip=%0d -> pad=%b", p, first_gap, glitch, late_flip, pad);
    endtask

    task automatic check_idle(input int n, input logic exp_pad);
        for (int i = 0; i < n; i++) begin
            step();
            total++; if (busy !== 1'b0 || done !== 1'b0 || pad !== exp_pad)
                $display("FAIL idle_after i=%0d got busy=%b done=%b pad=%b exp 0 0 %b", i, busy, done, pad, exp_pad); else passed++;
        end
    endtask

    task automatic test_press_release();
        run_seq(1'b1, 1'b1, 1'b0, 1'b0);
        check_idle(3, 1'b0);
        run_seq(1'b0, 1'b1, 1'b0, 1'b0);
        check_idle(3, 1'b1);
    endtask

    task automatic test_zero_bounce();
        press0 = 1'b1;
        step();
        total++; if (pad0 !== 1'b0 || busy0 !== 1'b1 || done0 !== 1'b0)
            $display("FAIL zb_entry got pad=%b busy=%b done=%b exp 0 1 0", pad0, busy0, done0); else passed++;
        for (int s = 1; s <= SC; s++) begin
            step();
            total++; if (pad0 !== 1'b0 || busy0 !== (s < SC) || done0 !== (s == SC))
                $display("FAIL zb_settle s=%0d got pad=%b busy=%b done=%b exp 0 %b %b", s, pad0, busy0, done0, (s < SC), (s == SC)); else passed++;
        end
        step();
        total++; if (busy0 !== 1'b0 || done0 !== 1'b0)
            $display("FAIL zb_after got busy=%b done=%b exp 0 0", busy0, done0); else passed++;
        $display("zero_bounce press=1 -> pad=%b", pad0);
    endtask

    task automatic test_glitch();
        run_seq(1'b1, 1'b1, 1'b1, 1'b0);
        check_idle(5, 1'b0);
        run_seq(1'b0, 1'b1, 1'b0, 1'b0);
        check_idle(2, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_seq(1'b1, 1'b1, 1'b0, 1'b1);
        run_seq(1'b0, 1'b0, 1'b0, 1'b0);
        check_idle(3, 1'b1);
    endtask

    task automatic test_reset_abort();
        int waited;
        press = 1'b1;
        waited = 0;
        while (pad !== 1'b0 && waited < 20) begin
            step();
            waited++;
        end
        total++; if (pad !== 1'b0 || busy !== 1'b1)
            $display("FAIL abort_setup got pad=%b busy=%b exp 0 1 after %0d cycles", pad, busy, waited); else passed++;
        #2 resetn = 1'b0;
        #1;
        total++; if (pad !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_async got pad=%b busy=%b done=%b exp 1 0 0", pad, busy, done); else passed++;
        press = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (done !== 1'b0 || pad !== 1'b1)
                $display("FAIL abort_hold i=%0d got done=%b pad=%b exp 0 1", i, done, pad); else passed++;
        end
        resetn = 1'b1;
        total++; if (dut.lfsr_reg !== 16'hACE1)
            $display("FAIL abort_seed got=%h exp=ace1", dut.lfsr_reg); else passed++;
        step();
        total++; if (dut.lfsr_reg !== 16'hE270 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_restart got lfsr=%h busy=%b done=%b exp e270 0 0", dut.lfsr_reg, busy, done); else passed++;
        $display("reset_abort: aborted after %0d cycles, pad=%b", waited, pad);
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_zero_bounce();
        test_glitch();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
